debug_pattern_generator3: RTL and testbench



---
 rtl/debug_pattern_generator3.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_debug_pattern_generator3.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_pattern_generator3.sv
// ---------------------------------------------------------------------------
// debug_pattern_generator3
//
// Generates test-pattern frames one row at a time into a pair of row buffers
// and announces them to a memory controller with a small command protocol.
// The controller reads the committed row through mem_addr/pixel_data while
// the next row is being filled into the other buffer.
//
// Ports:
//   clk_mem             sole clock, rising edge
//   reset               synchronous, active-high
//   init                starts (and keeps restarting) frame generation
//   mode                0 bars, 1 checker, 2 gradient, 3 solid
//   solid_color         RGB565 colour used by the solid mode
//   scroll_en           enables per-frame horizontal scroll
//   mem_controller_rdy  consumer accepts the current command
//   mem_addr            word address into the committed row
//   pixel_data          registered read word {odd column, even column}
//   command_data        1 frame start, 2 row ready, 3 frame end
//   command_data_valid  command valid
//   frame_count         completed frames (wraps)
//   busy                high in every state except IDLE
// ---------------------------------------------------------------------------
module debug_pattern_generator3 #(
  parameter int FRAME_WIDTH    = 640,
  parameter int FRAME_HEIGHT   = 480,
  parameter int NUM_COLOR_BARS = 8,
  parameter int CHECKER_LOG2   = 5,
  parameter int SCROLL_STEP    = 2,
  localparam int AW = $clog2(FRAME_WIDTH / 2)
) (
  input  logic          clk_mem,
  input  logic          reset,
  input  logic          init,
  input  logic [1:0]    mode,
  input  logic [15:0]   solid_color,
  input  logic          scroll_en,
  input  logic          mem_controller_rdy,
  input  logic [AW-1:0] mem_addr,
  output logic [31:0]   pixel_data,
  output logic [1:0]    command_data,
  output logic          command_data_valid,
  output logic [15:0]   frame_count,
  output logic          busy
);

  localparam int HALF = FRAME_WIDTH / 2;
  localparam int XW   = $clog2(FRAME_WIDTH);
  localparam int PW   = XW + 1;
  localparam int RW   = $clog2(FRAME_HEIGHT + 1);
  // A bar narrower than one pixel is meaningless; clamp so the counters work.
  localparam int BW   = (FRAME_WIDTH / NUM_COLOR_BARS) < 1 ? 1 : FRAME_WIDTH / NUM_COLOR_BARS;
  // Scroll step and frame width expressed as whole bars plus leftover pixels,
  // so the offset's bar position can be advanced without a divider.
  localparam int SB   = SCROLL_STEP / BW;
  localparam int SP   = SCROLL_STEP % BW;
  localparam int WB   = FRAME_WIDTH / BW;
  localparam int WP   = FRAME_WIDTH % BW;

  localparam logic [XW-1:0] X_LAST   = XW'(FRAME_WIDTH - 1);
  localparam logic [AW-1:0] COL_LAST = AW'(HALF - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);
  localparam logic [PW-1:0] BW_LAST  = PW'(BW - 1);

  localparam logic [15:0] PALETTE [16] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000,
    16'h8410, 16'hFD20, 16'h8010, 16'h0410, 16'h8000, 16'h0010, 16'h8400, 16'hC618
  };

  typedef enum logic [2:0] {
    S_IDLE, S_FRAME_START, S_FILL_ROW, S_ROW_CMD, S_FRAME_END
  } state_e;

  typedef enum logic [1:0] {
    MODE_BARS, MODE_CHECKER, MODE_GRADIENT, MODE_SOLID
  } mode_e;

  // Scrolled column together with its bar index and position inside the bar.
  typedef struct packed {
    logic [XW-1:0] x;
    logic [PW-1:0] bar;
    logic [PW-1:0] pos;
  } cursor_t;

  // Advance a cursor by one column, wrapping at the right edge of the frame.
  function automatic cursor_t step(input cursor_t c);
    cursor_t n;
    if (c.x == X_LAST) begin
      n = '0;
    end else begin
      n.x = c.x + XW'(1);
      if (c.pos == BW_LAST) begin
        n.bar = c.bar + PW'(1);
        n.pos = '0;
      end else begin
        n.bar = c.bar;
        n.pos = c.pos + PW'(1);
      end
    end
    return n;
  endfunction

  function automatic logic [15:0] pixel_of(input mode_e m, input logic [AW:0] xr,
                                           input cursor_t c, input logic [RW-1:0] r,
                                           input logic [15:0] solid);
    logic [5:0] g;
    logic       chk;
    logic [15:0] px;
    g   = 6'({c.x, 6'd0} / (XW + 6)'(FRAME_WIDTH));
    chk = 1'(xr >> CHECKER_LOG2) ^ 1'(r >> CHECKER_LOG2);
    case (m)
      MODE_BARS:     px = (32'(c.bar) < NUM_COLOR_BARS) ? PALETTE[4'(c.bar)] : 16'h0000;
      MODE_CHECKER:  px = chk ? 16'hFFFF : 16'h0000;
      MODE_GRADIENT: px = {g[5:1], g, g[5:1]};
      default:       px = solid;
    endcase
    return px;
  endfunction

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [15:0]   solid_q, solid_d;
  logic          scroll_q, scroll_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] col_q, col_d;
  logic          buf_id_q, buf_id_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [XW-1:0] offset_q, offset_d;
  logic [PW-1:0] off_bar_q, off_bar_d;
  logic [PW-1:0] off_pos_q, off_pos_d;
  cursor_t       cur_q, cur_d;

  logic [31:0]   buf0 [HALF];
  logic [31:0]   buf1 [HALF];
  logic [31:0]   pixel_data_q;

  logic          accept;
  cursor_t       cur_odd, start_cur;
  logic [31:0]   fill_word;
  logic [XW:0]   off_sum;
  logic [PW-1:0] pos1, bar1;
  logic [XW-1:0] off_x_nx;
  logic [PW-1:0] off_bar_nx, off_pos_nx;

  assign cur_odd   = step(cur_q);
  assign start_cur = scroll_q ? {offset_q, off_bar_q, off_pos_q} : '0;
  assign fill_word = {pixel_of(mode_q, {col_q, 1'b1}, cur_odd, row_q, solid_q),
                      pixel_of(mode_q, {col_q, 1'b0}, cur_q,   row_q, solid_q)};

  // Offset for the next frame, carried both as a column and as bar/position.
  // NOTE: blocking assignments inside always_comb are intentional -- pos1/bar1
  // are refined step by step within one evaluation, not stored between cycles.
  always_comb begin
    off_sum = {1'b0, offset_q} + (XW + 1)'(SCROLL_STEP);
    pos1    = off_pos_q + PW'(SP);
    bar1    = off_bar_q + PW'(SB);
    if (pos1 >= PW'(BW)) begin
      pos1 = pos1 - PW'(BW);
      bar1 = bar1 + PW'(1);
    end
    if (off_sum >= (XW + 1)'(FRAME_WIDTH)) begin
      off_x_nx = XW'(off_sum - (XW + 1)'(FRAME_WIDTH));
      if (pos1 < PW'(WP)) begin
        off_pos_nx = pos1 + PW'(BW) - PW'(WP);
        off_bar_nx = bar1 - PW'(WB) - PW'(1);
      end else begin
        off_pos_nx = pos1 - PW'(WP);
        off_bar_nx = bar1 - PW'(WB);
      end
    end else begin
      off_x_nx   = off_sum[XW-1:0];
      off_pos_nx = pos1;
      off_bar_nx = bar1;
    end
  end

  assign accept = command_data_valid && mem_controller_rdy;

  // NOTE: every _d gets its hold value first so no path through the case
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    solid_d       = solid_q;
    scroll_d      = scroll_q;
    row_d         = row_q;
    col_d         = col_q;
    buf_id_d      = buf_id_q;
    frame_count_d = frame_count_q;
    offset_d      = offset_q;
    off_bar_d     = off_bar_q;
    off_pos_d     = off_pos_q;
    cur_d         = start_cur;  // parked on the row's first column outside FILL_ROW

    case (state_q)
      S_IDLE: begin
        if (init) begin
          state_d  = S_FRAME_START;
          mode_d   = mode_e'(mode);
          solid_d  = solid_color;
          scroll_d = scroll_en;
        end
      end
      S_FRAME_START: begin
        if (accept) begin
          state_d = S_FILL_ROW;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_FILL_ROW: begin
        col_d = col_q + AW'(1);
        cur_d = step(cur_odd);
        if (col_q == COL_LAST) state_d = S_ROW_CMD;
      end
      S_ROW_CMD: begin
        if (accept) begin
          buf_id_d = ~buf_id_q;
          row_d    = row_q + RW'(1);
          col_d    = '0;
          state_d  = (row_q == ROW_LAST) ? S_FRAME_END : S_FILL_ROW;
        end
      end
      S_FRAME_END: begin
        if (accept) begin
          frame_count_d = frame_count_q + 16'd1;
          offset_d      = off_x_nx;
          off_bar_d     = off_bar_nx;
          off_pos_d     = off_pos_nx;
          mode_d        = mode_e'(mode);
          solid_d       = solid_color;
          scroll_d      = scroll_en;
          state_d       = init ? S_FRAME_START : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of block evaluation order.
  always_ff @(posedge clk_mem) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mode_q        <= MODE_BARS;
      solid_q       <= '0;
      scroll_q      <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
      buf_id_q      <= 1'b0;
      frame_count_q <= '0;
      offset_q      <= '0;
      off_bar_q     <= '0;
      off_pos_q     <= '0;
      cur_q         <= '0;
      pixel_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      solid_q       <= solid_d;
      scroll_q      <= scroll_d;
      row_q         <= row_d;
      col_q         <= col_d;
      buf_id_q      <= buf_id_d;
      frame_count_q <= frame_count_d;
      offset_q      <= offset_d;
      off_bar_q     <= off_bar_d;
      off_pos_q     <= off_pos_d;
      cur_q         <= cur_d;
      if (32'(mem_addr) < HALF)
        pixel_data_q <= buf_id_q ? buf1[mem_addr] : buf0[mem_addr];
      else
        pixel_data_q <= '0;
    end
  end

  // NOTE: the row buffers have no reset; their contents are always rewritten
  // before a row is committed, so clearing them would only cost logic.
  // The fill buffer is the one not currently committed for reading.
  always_ff @(posedge clk_mem) begin
    if (state_q == S_FILL_ROW) begin
      if (buf_id_q) buf0[col_q] <= fill_word;
      else          buf1[col_q] <= fill_word;
    end
  end

  always_comb begin
    command_data_valid = 1'b0;
    command_data       = 2'd0;
    case (state_q)
      S_FRAME_START: begin command_data_valid = 1'b1; command_data = 2'd1; end
      S_ROW_CMD:     begin command_data_valid = 1'b1; command_data = 2'd2; end
      S_FRAME_END:   begin command_data_valid = 1'b1; command_data = 2'd3; end
      default: ;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign frame_count = frame_count_q;
  assign pixel_data  = pixel_data_q;

endmodule

// File: tb/tb_debug_pattern_generator3.sv
// Directed bench for debug_pattern_generator3. Instance A: 16x2 frame, four
// bars, scroll step 2. Instance B: 8x4 frame with 2-pixel checker squares.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_debug_pattern_generator3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance A
  logic        a_reset, a_init, a_scroll, a_rdy, a_valid, a_busy;
  logic [1:0]  a_mode, a_cmd;
  logic [15:0] a_solid, a_fc;
  logic [2:0]  a_addr;
  logic [31:0] a_pix;

  // Instance B
  logic        b_reset, b_init, b_scroll, b_rdy, b_valid, b_busy;
  logic [1:0]  b_mode, b_cmd;
  logic [15:0] b_solid, b_fc;
  logic [1:0]  b_addr;
  logic [31:0] b_pix;

  debug_pattern_generator3 #(
    .FRAME_WIDTH(16), .FRAME_HEIGHT(2), .NUM_COLOR_BARS(4),
    .CHECKER_LOG2(5), .SCROLL_STEP(2)
  ) dut_a (
    .clk_mem(clk), .reset(a_reset), .init(a_init), .mode(a_mode),
    .solid_color(a_solid), .scroll_en(a_scroll), .mem_controller_rdy(a_rdy),
    .mem_addr(a_addr), .pixel_data(a_pix), .command_data(a_cmd),
    .command_data_valid(a_valid), .frame_count(a_fc), .busy(a_busy)
  );

  debug_pattern_generator3 #(
    .FRAME_WIDTH(8), .FRAME_HEIGHT(4), .NUM_COLOR_BARS(8),
    .CHECKER_LOG2(1), .SCROLL_STEP(2)
  ) dut_b (
    .clk_mem(clk), .reset(b_reset), .init(b_init), .mode(b_mode),
    .solid_color(b_solid), .scroll_en(b_scroll), .mem_controller_rdy(b_rdy),
    .mem_addr(b_addr), .pixel_data(b_pix), .command_data(b_cmd),
    .command_data_valid(b_valid), .frame_count(b_fc), .busy(b_busy)
  );

  // ---------------- stimulus helpers (bounded waits) ----------------
  task automatic wait_a(input string what);
    for (int i = 0; i < 300 && !a_valid; i++) @(negedge clk);
    if (!a_valid) begin
      n_assert++; n_fail++;
      $display("FAIL %s: timeout, valid=%0b required 1", what, a_valid);
    end
  endtask

  task automatic wait_b(input string what);
    for (int i = 0; i < 300 && !b_valid; i++) @(negedge clk);
    if (!b_valid) begin
      n_assert++; n_fail++;
      $display("FAIL %s: timeout, valid=%0b required 1", what, b_valid);
    end
  endtask

  task automatic wait_idle_a(input string what);
    for (int i = 0; i < 300 && a_busy; i++) @(negedge clk);
    if (a_busy) begin
      n_assert++; n_fail++;
      $display("FAIL %s: timeout, busy=%0b required 0", what, a_busy);
    end
  endtask

  task automatic accept_a();
    a_rdy = 1'b1; @(negedge clk); a_rdy = 1'b0;
  endtask

  task automatic accept_b();
    b_rdy = 1'b1; @(negedge clk); b_rdy = 1'b0;
  endtask

  task automatic read_a(input int addr, output logic [31:0] d);
    a_addr = 3'(addr); @(negedge clk); d = a_pix;
  endtask

  task automatic read_b(input int addr, output logic [31:0] d);
    b_addr = 2'(addr); @(negedge clk); d = b_pix;
  endtask

  task automatic pulse_init_a();
    a_init = 1'b1; @(negedge clk); a_init = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    a_reset = 1'b1; b_reset = 1'b1;
    repeat (3) @(negedge clk);
    a_reset = 1'b0; b_reset = 1'b0;
    n_assert++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", a_valid); end
    n_assert++; if (a_cmd !== 2'd0) begin n_fail++; $display("FAIL reset_cmd: got %0d want 0", a_cmd); end
    n_assert++; if (a_pix !== 32'h0) begin n_fail++; $display("FAIL reset_pixel: got %h want 0", a_pix); end
    n_assert++; if (a_fc !== 16'd0) begin n_fail++; $display("FAIL reset_frame_count: got %0d want 0", a_fc); end
    n_assert++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", a_busy); end
    n_assert++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b: got %0b want 0", b_busy); end
  endtask

  task automatic test_bars();
    logic [31:0] d;
    a_mode = 2'd0; a_scroll = 1'b0;
    pulse_init_a();
    wait_a("bars_start");
    n_assert++; if (a_cmd !== 2'd1) begin n_fail++; $display("FAIL bars_cmd1: got %0d want 1", a_cmd); end
    accept_a();
    wait_a("bars_row0");
    n_assert++; if (a_cmd !== 2'd2) begin n_fail++; $display("FAIL bars_cmd2a: got %0d want 2", a_cmd); end
    accept_a();
    read_a(0, d);
    n_assert++; if (d !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL bars_word0: got %h want ffffffff", d); end
    read_a(2, d);
    n_assert++; if (d !== 32'hFFE0FFE0) begin n_fail++; $display("FAIL bars_word2: got %h want ffe0ffe0", d); end
    read_a(4, d);
    n_assert++; if (d !== 32'h07FF07FF) begin n_fail++; $display("FAIL bars_word4: got %h want 07ff07ff", d); end
    read_a(7, d);
    n_assert++; if (d !== 32'h07E007E0) begin n_fail++; $display("FAIL bars_word7: got %h want 07e007e0", d); end
    wait_a("bars_row1");
    n_assert++; if (a_cmd !== 2'd2) begin n_fail++; $display("FAIL bars_cmd2b: got %0d want 2", a_cmd); end
    accept_a();
    wait_a("bars_end");
    n_assert++; if (a_cmd !== 2'd3) begin n_fail++; $display("FAIL bars_cmd3: got %0d want 3", a_cmd); end
    accept_a();
    n_assert++; if (a_fc !== 16'd1) begin n_fail++; $display("FAIL bars_frame_count: got %0d want 1", a_fc); end
    n_assert++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL bars_idle: busy=%0b want 0", a_busy); end
  endtask

  task automatic test_backpressure();
    a_rdy = 1'b0;
    pulse_init_a();
    wait_a("bp_start");
    for (int i = 0; i < 10; i++) begin
      n_assert++;
      if (a_valid !== 1'b1 || a_cmd !== 2'd1) begin
        n_fail++; $display("FAIL bp_hold cycle %0d: valid=%0b cmd=%0d want 1/1", i, a_valid, a_cmd);
      end
      @(negedge clk);
    end
    a_rdy = 1'b1;
    @(negedge clk);
    n_assert++; if (a_valid !== 1'b0 || a_busy !== 1'b1) begin
      n_fail++; $display("FAIL bp_advance: valid=%0b busy=%0b want 0/1", a_valid, a_busy);
    end
    wait_idle_a("bp_finish");
    a_rdy = 1'b0;
    n_assert++; if (a_fc !== 16'd2) begin n_fail++; $display("FAIL bp_frame_count: got %0d want 2", a_fc); end
  endtask

  task automatic test_solid_latch();
    logic [31:0] d;
    a_mode = 2'd3; a_solid = 16'hF800;
    pulse_init_a();
    a_mode = 2'd0; a_solid = 16'h001F;  // changes after latching must be ignored
    wait_a("solid_start");
    accept_a();
    for (int r = 0; r < 2; r++) begin
      wait_a("solid_row");
      accept_a();
      for (int w = 0; w < 8; w++) begin
        read_a(w, d);
        n_assert++;
        if (d !== 32'hF800F800) begin
          n_fail++; $display("FAIL solid_r%0d_w%0d: got %h want f800f800", r, w, d);
        end
      end
    end
    wait_a("solid_end");
    n_assert++; if (a_cmd !== 2'd3) begin n_fail++; $display("FAIL solid_cmd3: got %0d want 3", a_cmd); end
    accept_a();
    n_assert++; if (a_fc !== 16'd3) begin n_fail++; $display("FAIL solid_frame_count: got %0d want 3", a_fc); end
  endtask

  task automatic test_reset_mid_frame();
    a_mode = 2'd0;
    pulse_init_a();
    wait_a("rst_start");
    accept_a();
    wait_a("rst_row0");
    accept_a();
    repeat (2) @(negedge clk);  // inside FILL_ROW of row 1
    a_reset = 1'b1;
    @(negedge clk);
    a_reset = 1'b0;
    n_assert++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %0b want 0", a_valid); end
    n_assert++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %0b want 0", a_busy); end
    n_assert++; if (a_fc !== 16'd0) begin n_fail++; $display("FAIL rstmid_frame_count: got %0d want 0", a_fc); end
    n_assert++; if (a_pix !== 32'h0) begin n_fail++; $display("FAIL rstmid_pixel: got %h want 0", a_pix); end
    pulse_init_a();
    wait_a("rstmid_restart");
    n_assert++; if (a_cmd !== 2'd1) begin n_fail++; $display("FAIL rstmid_restart_cmd: got %0d want 1", a_cmd); end
    a_rdy = 1'b1;
    wait_idle_a("rstmid_finish");
    a_rdy = 1'b0;
    n_assert++; if (a_fc !== 16'd1) begin n_fail++; $display("FAIL rstmid_frame_count_after: got %0d want 1", a_fc); end
  endtask

  task automatic test_scroll();
    logic [31:0] d;
    a_reset = 1'b1; @(negedge clk); a_reset = 1'b0;
    a_mode = 2'd2; a_scroll = 1'b1; a_init = 1'b1;
    // Frame 1: offset 0
    wait_a("scroll_f1_start"); accept_a();
    wait_a("scroll_f1_row0"); accept_a();
    read_a(0, d);
    n_assert++; if (d !== 32'h10820000) begin n_fail++; $display("FAIL scroll_f1_word0: got %h want 10820000", d); end
    wait_a("scroll_f1_row1"); accept_a();
    wait_a("scroll_f1_end"); accept_a();
    // Frame 2: offset 2, starts directly because init is still high
    wait_a("scroll_f2_start");
    n_assert++; if (a_cmd !== 2'd1) begin n_fail++; $display("FAIL scroll_f2_cmd1: got %0d want 1", a_cmd); end
    accept_a();
    a_init = 1'b0;
    wait_a("scroll_f2_row0"); accept_a();
    read_a(0, d);
    n_assert++; if (d !== 32'h31862104) begin n_fail++; $display("FAIL scroll_f2_word0: got %h want 31862104", d); end
    read_a(7, d);
    n_assert++; if (d !== 32'h10820000) begin n_fail++; $display("FAIL scroll_f2_word7_wrap: got %h want 10820000", d); end
    wait_a("scroll_f2_row1"); accept_a();
    wait_a("scroll_f2_end"); accept_a();
    n_assert++; if (a_fc !== 16'd2 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL scroll_done: frame_count=%0d busy=%0b want 2/0", a_fc, a_busy);
    end
  endtask

  task automatic test_checker();
    logic [31:0] d;
    logic [31:0] exp_row0 [4];
    exp_row0 = '{32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    b_mode = 2'd1;
    b_init = 1'b1; @(negedge clk); b_init = 1'b0;
    wait_b("chk_start"); accept_b();
    wait_b("chk_row0"); accept_b();
    for (int w = 0; w < 4; w++) begin
      read_b(w, d);
      n_assert++;
      if (d !== exp_row0[w]) begin n_fail++; $display("FAIL chk_row0_w%0d: got %h want %h", w, d, exp_row0[w]); end
    end
    wait_b("chk_row1"); accept_b();
    wait_b("chk_row2"); accept_b();
    for (int w = 0; w < 2; w++) begin
      read_b(w, d);
      n_assert++;
      if (d !== ~exp_row0[w]) begin n_fail++; $display("FAIL chk_row2_w%0d: got %h want %h", w, d, ~exp_row0[w]); end
    end
    wait_b("chk_row3"); accept_b();
    wait_b("chk_end");
    n_assert++; if (b_cmd !== 2'd3) begin n_fail++; $display("FAIL chk_cmd3: got %0d want 3", b_cmd); end
    accept_b();
    n_assert++; if (b_fc !== 16'd1 || b_busy !== 1'b0) begin
      n_fail++; $display("FAIL chk_done: frame_count=%0d busy=%0b want 1/0", b_fc, b_busy);
    end
  endtask

  initial begin
    a_reset = 1'b1; a_init = 1'b0; a_mode = 2'd0; a_solid = 16'h0; a_scroll = 1'b0;
    a_rdy = 1'b0; a_addr = '0;
    b_reset = 1'b1; b_init = 1'b0; b_mode = 2'd0; b_solid = 16'h0; b_scroll = 1'b0;
    b_rdy = 1'b0; b_addr = '0;
    @(negedge clk);
    test_reset();
    test_bars();
    test_backpressure();
    test_solid_latch();
    test_reset_mid_frame();
    test_scroll();
    test_checker();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
